// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// The state enum, the sequential PC step and the reset PC live here so that later fetch blocks agree on them.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } ifetch_state_e;

  localparam int unsigned DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry instruction/PC holding register with a valid/ready output handshake.
// A flush drops the entry and has priority over a load in the same cycle.
module ifetch_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fire
);

  assign fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_pc    <= load_pc;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: issues one memory read per PC, buffers the instruction for decode,
// and steers next_pc (hold / pc+step / redirect) back into an enable-less PC register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_REQ   | request for the current pc offered to instruction memory
//   S_WAIT  | request accepted, waiting for its response
//   S_HOLD  | instruction buffered, waiting for decode to take it
//   S_DRAIN | redirected while waiting; discard the stale response
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_STEP  = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  ifetch_state_e state, state_nxt;
  logic          buf_load;
  logic          buf_fire;

  assign imem_req_addr = {pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    next_pc        = pc;
    imem_req_valid = 1'b0;
    buf_load       = 1'b0;

    unique case (state)
      S_REQ: begin
        // A redirect suppresses the request so no read goes out for a stale pc.
        if (redirect_valid) begin
          next_pc = redirect_pc;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          next_pc   = redirect_pc;
          state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          buf_load  = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          next_pc = redirect_pc;
        end
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          next_pc   = redirect_pc;
          state_nxt = S_REQ;
        end else if (buf_fire) begin
          next_pc   = pc + ADDR_W'(PC_STEP);
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase

    if (!rst_n) begin
      imem_req_valid = 1'b0;
      next_pc        = RESET_PC;
    end
  end

  // The entry is only ever valid in S_HOLD, so a redirect can flush it unconditionally.
  ifetch_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_data (imem_rsp_data),
    .load_pc   (pc),
    .flush     (redirect_valid),
    .out_valid (inst_valid),
    .out_ready (inst_ready),
    .out_data  (inst_data),
    .out_pc    (inst_pc),
    .fire      (buf_fire)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: models the PC register, a variable-latency memory and decode,
// and scores delivered instructions against an architectural fetch-stream model.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  ifetch_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .PC_STEP  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .next_pc        (next_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  // Stimulus knobs, written by the sequencer at posedge+2 and read by the environment at posedge+1.
  int          rdy_p = 100, dec_p = 100, redir_p = 0, lat_min = 1, lat_max = 1, phase = 0;
  bit          force_redir = 1'b0, force_ird = 1'b0;
  logic [31:0] force_target = '0;

  int          n_checks = 0, n_pass = 0, n_deliv = 0;
  longint      cyc = 0, last_del = -1;

  // Expected fetch stream: head is the pc of the next instruction decode should receive.
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = '0;

  bit          s_rst, s_acc, s_del;
  logic [31:0] s_next, s_addr;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  bit          rise_pend = 1'b0, keep_pend = 1'b0, outst = 1'b0, live = 1'b0;
  bit          exp_iv, exp_rv;
  logic [31:0] exp_np;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0200) return 32'hDEAD_BEEF;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Environment: PC register, memory, decode and redirect source.
  initial begin : env
    forever begin
      @(negedge clk);
      s_rst  = rst_n;
      s_acc  = rst_n && imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      s_next = next_pc;
      s_del  = rst_n && inst_valid && inst_ready && !redirect_valid;
      @(posedge clk);
      #1;
      pc = s_next;
      if (!s_rst) begin
        exp_q.delete();
        model_pc = 32'h0;
        exp_q.push_back(model_pc);
        mem_pend = 1'b0;
      end else begin
        if (s_del) begin
          model_pc = model_pc + 32'd4;
          exp_q.push_back(model_pc);
        end
        if (s_acc) begin
          mem_pend = 1'b1;
          mem_cnt  = $urandom_range(lat_max, lat_min);
          mem_addr = s_addr;
        end
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
          mem_pend       = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      imem_req_ready = ($urandom_range(99, 0) < rdy_p);
      inst_ready     = force_ird || ($urandom_range(99, 0) < dec_p);
      force_ird      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_target;
        force_redir    = 1'b0;
      end else if ($urandom_range(99, 0) < redir_p) begin
        redirect_valid = 1'b1;
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_pc;
        exp_q.push_back(model_pc);
      end
    end
  end

  // Monitor: per-cycle protocol model plus scoreboard pop on each delivery.
  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      exp_iv = rise_pend || keep_pend;
      check("inst_valid", inst_valid, exp_iv);
      exp_rv = rst_n && !redirect_valid && !exp_iv && !outst;
      check("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) check("req_addr", imem_req_addr, {pc[31:2], 2'b00});
      if (!rst_n)              exp_np = 32'h0;
      else if (redirect_valid) exp_np = redirect_pc;
      else if (exp_iv && inst_ready) exp_np = pc + 32'd4;
      else                     exp_np = pc;
      check("next_pc", next_pc, exp_np);
      if (rst_n && exp_iv && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard: instruction pc %0h with nothing expected", inst_pc);
        end else begin
          check("inst_pc", inst_pc, exp_q[0]);
          check("inst_data", inst_data, mem_word(exp_q[0]));
          if (inst_ready) begin
            void'(exp_q.pop_front());
            n_deliv++;
            if (phase == 1 && last_del >= 0) check("deliv_gap", cyc - last_del, 3);
            last_del = cyc;
          end
        end
      end
      rise_pend = rst_n && imem_rsp_valid && live && !redirect_valid;
      keep_pend = rst_n && exp_iv && !inst_ready && !redirect_valid;
      if (!rst_n) begin
        outst = 1'b0;
        live  = 1'b0;
      end else begin
        if (imem_rsp_valid) begin
          outst = 1'b0;
          live  = 1'b0;
        end
        if (redirect_valid) live = 1'b0;
        if (exp_rv && imem_req_ready) begin
          outst = 1'b1;
          live  = 1'b1;
        end
      end
    end
  end

  initial begin : seq
    bit ok;
    int n0;
    rst_n = 1'b0; pc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (3) step();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_next_pc", next_pc, 32'h0);

    // Streaming from pc 0 with everything ready and a 1-cycle memory.
    phase = 1;
    rst_n = 1'b1;
    repeat (13) step();
    check("stream_deliveries", n_deliv >= 4, 1);
    phase = 0;

    // Memory back-pressure.
    rdy_p = 0;
    repeat (5) step();
    check("stall_req_valid", imem_req_valid, 1);
    check("stall_addr", imem_req_addr, {pc[31:2], 2'b00});
    check("stall_next_pc", next_pc, pc);
    rdy_p = 100;
    repeat (4) step();

    // Decode back-pressure on a known word.
    dec_p = 0; force_target = 32'h200; force_redir = 1'b1;
    step(); step();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin ok = 1'b1; break; end
      step();
    end
    check("wait_deadbeef", ok, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_valid", inst_valid, 1);
      check("hold_data", inst_data, 32'hDEAD_BEEF);
      check("hold_pc", inst_pc, 32'h200);
      check("hold_no_req", imem_req_valid, 0);
    end
    n0 = n_deliv; force_ird = 1'b1;
    step();
    check("hs_next_pc", next_pc, 32'h204);
    step(); step();
    check("hs_once", n_deliv - n0, 1);
    dec_p = 100;

    // Redirect while waiting on a 3-cycle response.
    lat_min = 3; lat_max = 3;
    step();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid && imem_req_ready) begin ok = 1'b1; break; end
      step();
    end
    check("wait_accept", ok, 1);
    force_target = 32'h100; force_redir = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("drain_no_inst", inst_valid, 0);
    end
    check("drain_req_valid", imem_req_valid, 1);
    check("drain_req_addr", imem_req_addr, 32'h100);

    // Redirect in S_HOLD together with inst_ready.
    lat_min = 1; lat_max = 1; dec_p = 0;
    step();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin ok = 1'b1; break; end
      step();
    end
    check("wait_hold", ok, 1);
    force_target = 32'h300; force_redir = 1'b1; force_ird = 1'b1;
    n0 = n_deliv;
    step();
    check("hold_redir_next_pc", next_pc, 32'h300);
    step();
    check("hold_redir_flushed", inst_valid, 0);
    check("hold_redir_no_deliv", n_deliv - n0, 0);
    dec_p = 100;

    // PC wrap at the top of the address space.
    force_target = 32'hFFFF_FFFC; force_redir = 1'b1;
    step(); step();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid && inst_ready) begin ok = 1'b1; break; end
      step();
    end
    check("wait_wrap", ok, 1);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_next_pc", next_pc, 32'h0);

    // Reset while waiting on memory.
    lat_min = 3; lat_max = 3;
    step();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid && imem_req_ready) begin ok = 1'b1; break; end
      step();
    end
    check("wait_accept2", ok, 1);
    step();
    rst_n = 1'b0;
    step();
    check("midrst_req_valid", imem_req_valid, 0);
    check("midrst_next_pc", next_pc, 32'h0);
    check("midrst_inst_valid", inst_valid, 0);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin ok = 1'b1; break; end
      step();
    end
    check("restart_inst", ok, 1);
    check("restart_pc", inst_pc, 32'h0);

    // Randomized traffic.
    n0 = n_deliv;
    rdy_p = 70; dec_p = 60; redir_p = 8; lat_min = 1; lat_max = 4;
    repeat (3000) step();
    redir_p = 0; rdy_p = 100; dec_p = 100;
    repeat (20) step();
    check("random_deliveries", (n_deliv - n0) > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Fetch-side consumer of the PC register. Reads the current PC, issues one instruction-memory read per PC over a valid/ready request channel, and accepts a variable-latency response. It buffers the instruction in a one-entry output register with a valid/ready handshake to decode. It drives next_pc back into the PC register: hold, pc+4, or branch redirect. The PC register has no enable, so holding is done by next_pc = pc.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width
PC_STEP, 4, byte increment per sequential instruction
RESET_PC, 0, next_pc value driven while reset is asserted

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
pc  in  ADDR_W  current PC from the PC register
next_pc  out  ADDR_W  value loaded into the PC register at the next edge
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word-aligned address {pc[ADDR_W-1:2],2'b00}
imem_rsp_valid  in  1  read data valid; one response per accepted request, in order
imem_rsp_data  in  DATA_W  read data
redirect_valid  in  1  branch/jump taken, single-cycle pulse
redirect_pc  in  ADDR_W  redirect target
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction
inst_data  out  DATA_W  buffered instruction
inst_pc  out  ADDR_W  PC of the buffered instruction

Behaviour:
- Interface fixed: one clock (clk); reset synchronous, active-low (rst_n).
- States: S_REQ, S_WAIT, S_HOLD, S_DRAIN. Reset state is S_REQ.
- While rst_n=0 (sampled at clk): state<=S_REQ, inst_valid<=0, inst_data<=0, inst_pc<=0. Combinationally, imem_req_valid=0 and next_pc=RESET_PC.
- The memory shares rst_n, so no response survives reset. Reset mid-WAIT or mid-DRAIN simply abandons the transaction.
- Default next_pc = pc (hold) unless a rule below says otherwise.
- S_REQ:
  - imem_req_valid=1, addr from pc.
  - Handshake fires when valid&&ready: go to S_WAIT.
  - If redirect_valid is high: imem_req_valid is forced 0 that cycle (no request for a stale PC), next_pc=redirect_pc, and the state stays S_REQ.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: inst_data<=rsp_data, inst_pc<=pc, inst_valid<=1, go to S_HOLD.
  - If redirect_valid is high: next_pc=redirect_pc.
    - If rsp_valid is high the same cycle, the response is dropped and the state goes to S_REQ.
    - Otherwise go to S_DRAIN.
- S_DRAIN: wait for imem_rsp_valid, discard the data, then go to S_REQ. A redirect here updates next_pc only (latest target wins).
- S_HOLD:
  - inst_valid=1; inst_data and inst_pc stable until the handshake completes.
  - On inst_valid&&inst_ready: next_pc=pc+PC_STEP (wraps modulo 2^ADDR_W), inst_valid<=0, go to S_REQ.
  - If redirect_valid is high (priority over inst_ready): next_pc=redirect_pc, inst_valid<=0, and the instruction is not delivered; go to S_REQ.
- imem_rsp_valid in S_REQ or S_HOLD is a protocol error; it is ignored with no state change.
- Latency: from request accept with a 1-cycle memory, inst_valid rises 2 cycles later. Minimum 3 cycles per instruction (REQ, WAIT, HOLD).
- pc[1:0] is ignored; no misalignment trap.

Decomposition:
- Package ifetch_pkg: state enum (S_REQ, S_WAIT, S_HOLD, S_DRAIN, 2-bit encoding), PC_STEP, and the default RESET_PC constant.
- Natural sub-module: ifetch_buf, the one-entry instruction/PC holding register with valid/ready handshake, reused later for decode-stage skid buffering.
- FSM and next_pc mux stay in ifetch_ctrl.

Test Plan:
- Reset, then imem always ready, 1-cycle response, decode always ready, pc=0: requests at 0x0, 0x4, 0x8. Instructions delivered with inst_pc 0,4,8, one every 3 cycles. next_pc=pc+4 only on the delivery cycle.
- Memory holds imem_req_ready=0 for 5 cycles: imem_req_valid stays 1, address stable at pc, next_pc=pc throughout.
- Instruction 0xDEADBEEF delivered, inst_ready=0 for 4 cycles: inst_valid, inst_data and inst_pc held stable, no new request. inst_ready=1 then fires exactly one handshake.
- redirect_valid with target 0x100 in S_WAIT, response 3 cycles later: the response is dropped and inst_valid is never set. The next request address is 0x100.
- redirect_valid in S_HOLD together with inst_ready=1: the instruction is not consumed, inst_valid falls, and next_pc=redirect_pc.
- pc=0xFFFFFFFC delivered: next_pc=0x00000000. Asserting rst_n=0 in S_WAIT clears inst_valid and imem_req_valid, forces next_pc=0, and fetch restarts from S_REQ.
